// File: rtl/xgmii_decoder.sv
`default_nettype none
// ============================================================================
// Module   : xgmii_decoder
// Function : 64b/66b receive decoder. Reassembles 66-bit blocks from two
//            32-bit halves, decodes them into two 32-bit XGMII words with
//            per-lane control flags, enforces start/data/terminate ordering
//            and flags decoding violations.
// Revision : 1.0 - initial release
// ============================================================================
module xgmii_decoder #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4,
    parameter int HDR_WIDTH  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [HDR_WIDTH-1:0]  i_rx_sync_hdr,
    input  logic                  i_rx_hdr_valid,
    input  logic                  i_rx_valid,
    output logic [DATA_WIDTH-1:0] o_xgmii_rxd,
    output logic [CTRL_WIDTH-1:0] o_xgmii_rxc,
    output logic                  o_xgmii_valid,
    output logic                  o_decode_err
);

    localparam logic [7:0] C_IDLE  = 8'h07;
    localparam logic [7:0] C_START = 8'hFB;
    localparam logic [7:0] C_TERM  = 8'hFD;
    localparam logic [7:0] C_ERROR = 8'hFE;
    localparam logic [7:0] C_SEQ   = 8'h9C;

    typedef enum logic [0:0] {HALF0 = 1'b0, HALF1 = 1'b1} asm_state_t;
    typedef enum logic [0:0] {IDLE = 1'b0, IN_FRAME = 1'b1} frame_state_t;

    asm_state_t   r_asm_state;
    frame_state_t r_frame;
    frame_state_t w_frame_nxt;

    logic [31:0] r_lo;
    logic [1:0]  r_hdr;

    logic [31:0] r_rxd;
    logic [3:0]  r_rxc;
    logic        r_valid;
    logic        r_err;
    logic [31:0] r_pend_rxd;
    logic [3:0]  r_pend_rxc;
    logic        r_pend_valid;

    logic        w_blk_done;
    logic        w_misalign;
    logic [63:0] w_payload;
    logic [63:0] w_shift;
    logic [7:0]  w_type;
    logic        w_term_hit;
    logic [2:0]  w_term_k;
    logic [63:0] w_rxd;
    logic [7:0]  w_rxc;
    logic        w_err;
    logic        w_bad;

    // A block completes on a second-half beat; a beat arriving out of
    // header order is a misalignment.
    assign w_blk_done = i_rx_valid && (r_asm_state == HALF1) && !i_rx_hdr_valid;
    assign w_misalign = i_rx_valid &&
                        (((r_asm_state == HALF0) && !i_rx_hdr_valid) ||
                         ((r_asm_state == HALF1) &&  i_rx_hdr_valid));

    assign w_payload = {i_rx_data, r_lo};
    assign w_shift   = w_payload >> 8;
    assign w_type    = w_payload[7:0];

    // Half assembler: latch the first half and header, restart on a stray header beat.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_asm_state <= HALF0;
            r_lo        <= 32'h0;
            r_hdr       <= 2'b00;
        end else if (i_rx_valid) begin
            if (i_rx_hdr_valid) begin
                r_lo        <= i_rx_data;
                r_hdr       <= i_rx_sync_hdr;
                r_asm_state <= HALF1;
            end else begin
                r_asm_state <= HALF0;
            end
        end
    end

    // Map terminate block types to the lane holding /T/.
    always_comb begin
        w_term_hit = 1'b1;
        w_term_k   = 3'd0;
        case (w_type)
            8'h87:   w_term_k = 3'd0;
            8'h99:   w_term_k = 3'd1;
            8'hAA:   w_term_k = 3'd2;
            8'hB4:   w_term_k = 3'd3;
            8'hCC:   w_term_k = 3'd4;
            8'hD2:   w_term_k = 3'd5;
            8'hE1:   w_term_k = 3'd6;
            8'hFF:   w_term_k = 3'd7;
            default: w_term_hit = 1'b0;
        endcase
    end

    // Block decode and frame sequencing; any violation collapses to an error block.
    always_comb begin
        w_rxd       = {8{C_ERROR}};
        w_rxc       = 8'hFF;
        w_err       = 1'b0;
        w_bad       = 1'b0;
        w_frame_nxt = r_frame;
        case (r_hdr)
            2'b01: begin
                w_rxd = w_payload;
                w_rxc = 8'h00;
                if (r_frame == IDLE) w_bad = 1'b1;
            end
            2'b10: begin
                if (w_type == 8'h1E) begin
                    // Eight 7-bit control codes; only idle and error are legal.
                    for (int i = 0; i < 8; i++) begin
                        if (w_payload[8+7*i +: 7] == 7'h00) begin
                            w_rxd[8*i +: 8] = C_IDLE;
                        end else begin
                            w_rxd[8*i +: 8] = C_ERROR;
                            if (w_payload[8+7*i +: 7] != 7'h1E) w_err = 1'b1;
                        end
                    end
                    w_rxc = 8'hFF;
                    if (r_frame == IN_FRAME) w_bad = 1'b1;
                end else if (w_type == 8'h78) begin
                    w_rxd = {w_payload[63:8], C_START};
                    w_rxc = 8'h01;
                    if (r_frame == IN_FRAME) w_bad = 1'b1;
                    else                     w_frame_nxt = IN_FRAME;
                end else if (w_type == 8'h33) begin
                    w_rxd = {w_payload[63:40], C_START, {4{C_IDLE}}};
                    w_rxc = 8'h1F;
                    if (r_frame == IN_FRAME) w_bad = 1'b1;
                    else                     w_frame_nxt = IN_FRAME;
                end else if (w_type == 8'h4B) begin
                    w_rxd = {{4{C_IDLE}}, w_payload[31:8], C_SEQ};
                    w_rxc = 8'hF1;
                    if (r_frame == IN_FRAME) w_bad = 1'b1;
                end else if (w_term_hit) begin
                    // Data ahead of /T/ shifts down one lane past the type byte.
                    for (int j = 0; j < 8; j++) begin
                        if (j < int'(w_term_k)) begin
                            w_rxd[8*j +: 8] = w_shift[8*j +: 8];
                            w_rxc[j]        = 1'b0;
                        end else if (j == int'(w_term_k)) begin
                            w_rxd[8*j +: 8] = C_TERM;
                            w_rxc[j]        = 1'b1;
                        end else begin
                            w_rxd[8*j +: 8] = C_IDLE;
                            w_rxc[j]        = 1'b1;
                        end
                    end
                    if (r_frame == IN_FRAME) w_frame_nxt = IDLE;
                    else                     w_bad = 1'b1;
                end else begin
                    w_bad = 1'b1;
                end
            end
            default: w_bad = 1'b1;
        endcase
        if (w_bad) begin
            w_rxd       = {8{C_ERROR}};
            w_rxc       = 8'hFF;
            w_err       = 1'b1;
            w_frame_nxt = IDLE;
        end
    end

    // Output stage: emit the low word of a decoded block, queue the high word
    // for the next cycle, and advance the frame state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rxd        <= {4{C_IDLE}};
            r_rxc        <= 4'hF;
            r_valid      <= 1'b0;
            r_err        <= 1'b0;
            r_pend_rxd   <= 32'h0;
            r_pend_rxc   <= 4'h0;
            r_pend_valid <= 1'b0;
            r_frame      <= IDLE;
        end else begin
            r_err <= w_misalign || (w_blk_done && w_err);
            if (w_blk_done) begin
                r_rxd        <= w_rxd[31:0];
                r_rxc        <= w_rxc[3:0];
                r_valid      <= 1'b1;
                r_pend_rxd   <= w_rxd[63:32];
                r_pend_rxc   <= w_rxc[7:4];
                r_pend_valid <= 1'b1;
                r_frame      <= w_frame_nxt;
            end else if (r_pend_valid) begin
                r_rxd        <= r_pend_rxd;
                r_rxc        <= r_pend_rxc;
                r_valid      <= 1'b1;
                r_pend_valid <= 1'b0;
            end else begin
                r_valid      <= 1'b0;
            end
        end
    end

    assign o_xgmii_rxd   = r_rxd;
    assign o_xgmii_rxc   = r_rxc;
    assign o_xgmii_valid = r_valid;
    assign o_decode_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_xgmii_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_xgmii_decoder
// Function : Scoreboard bench for xgmii_decoder. Stimulus queues expected
//            words (with expected arrival cycle); a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xgmii_decoder;

    logic        clk;
    logic        rst;
    logic [31:0] rx_data;
    logic [1:0]  rx_sync_hdr;
    logic        rx_hdr_valid;
    logic        rx_valid;
    logic [31:0] xgmii_rxd;
    logic [3:0]  xgmii_rxc;
    logic        xgmii_valid;
    logic        decode_err;

    typedef struct {
        int unsigned cyc;
        logic [31:0] rxd;
        logic [3:0]  rxc;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned lone_q[$];
    int unsigned cyc;
    int          n_cmp;
    int          n_bad;
    logic [31:0] last_rxd;
    logic [3:0]  last_rxc;

    xgmii_decoder #(.DATA_WIDTH(32), .CTRL_WIDTH(4), .HDR_WIDTH(2)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_rx_data      (rx_data),
        .i_rx_sync_hdr  (rx_sync_hdr),
        .i_rx_hdr_valid (rx_hdr_valid),
        .i_rx_valid     (rx_valid),
        .o_xgmii_rxd    (xgmii_rxd),
        .o_xgmii_rxc    (xgmii_rxc),
        .o_xgmii_valid  (xgmii_valid),
        .o_decode_err   (decode_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every valid word, every lone error pulse and output hold in gaps.
    always @(negedge clk) begin
        if (rst) begin
            last_rxd = 32'h07070707;
            last_rxc = 4'hF;
        end else if (cyc > 0) begin
            if (xgmii_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {32'h0, xgmii_rxd}, 64'hDEAD);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("word_cycle", 64'(cyc), 64'(e.cyc));
                    chk("rxd", 64'(xgmii_rxd), 64'(e.rxd));
                    chk("rxc", 64'(xgmii_rxc), 64'(e.rxc));
                    chk("err", 64'(decode_err), 64'(e.err));
                end
                last_rxd = xgmii_rxd;
                last_rxc = xgmii_rxc;
            end else begin
                chk("hold_rxd", 64'(xgmii_rxd), 64'(last_rxd));
                chk("hold_rxc", 64'(xgmii_rxc), 64'(last_rxc));
                if (decode_err) begin
                    if (lone_q.size() == 0) chk("unexpected_err", 64'(decode_err), 64'h0);
                    else                    chk("lone_err_cycle", 64'(cyc), 64'(lone_q.pop_front()));
                end
            end
        end
    end

    task automatic beat(input logic hv, input logic [1:0] hdr, input logic [31:0] d);
        @(negedge clk);
        rx_valid     = 1'b1;
        rx_hdr_valid = hv;
        rx_sync_hdr  = hdr;
        rx_data      = d;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_valid     = 1'b0;
            rx_hdr_valid = 1'b0;
        end
    endtask

    task automatic send(input logic [1:0] hdr, input logic [31:0] lo, input logic [31:0] hi,
                        input logic [31:0] w0, input logic [3:0] c0,
                        input logic [31:0] w1, input logic [3:0] c1, input logic err);
        exp_t e;
        beat(1'b1, hdr, lo);
        beat(1'b0, 2'b00, hi);
        e.cyc = cyc + 1; e.rxd = w0; e.rxc = c0; e.err = err;
        exp_q.push_back(e);
        e.cyc = cyc + 2; e.rxd = w1; e.rxc = c1; e.err = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rxd"},   64'(xgmii_rxd),   64'h07070707);
        chk({tag, "_rxc"},   64'(xgmii_rxc),   64'hF);
        chk({tag, "_valid"}, 64'(xgmii_valid), 64'h0);
        chk({tag, "_err"},   64'(decode_err),  64'h0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; rx_valid = 1'b0; rx_hdr_valid = 1'b0; rx_sync_hdr = 2'b00; rx_data = 32'h0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        gap(2);

        // Idle block
        send(2'b10, 32'h0000001E, 32'h0, 32'h07070707, 4'hF, 32'h07070707, 4'hF, 1'b0);
        gap(2);
        // Back-to-back frame: start, data, terminate at lane 0
        send(2'b10, 32'h55555578, 32'h55555555, 32'h555555FB, 4'h1, 32'h55555555, 4'h0, 1'b0);
        send(2'b01, 32'hDDCCBBAA, 32'h44332211, 32'hDDCCBBAA, 4'h0, 32'h44332211, 4'h0, 1'b0);
        send(2'b10, 32'h00000087, 32'h0,        32'h070707FD, 4'hF, 32'h07070707, 4'hF, 1'b0);
        gap(3);
        // Start at lane 4, terminate at lane 4
        send(2'b10, 32'h00000033, 32'h77665500, 32'h07070707, 4'hF, 32'h776655FB, 4'h1, 1'b0);
        send(2'b10, 32'h332211CC, 32'h00000044, 32'h44332211, 4'h0, 32'h070707FD, 4'hF, 1'b0);
        gap(2);
        // Invalid header and unknown type
        send(2'b11, 32'h0000001E, 32'h0, 32'hFEFEFEFE, 4'hF, 32'hFEFEFEFE, 4'hF, 1'b1);
        send(2'b10, 32'h0000005A, 32'h0, 32'hFEFEFEFE, 4'hF, 32'hFEFEFEFE, 4'hF, 1'b1);
        // Data while idle, then a normal start and terminate at lane 7
        send(2'b01, 32'h12345678, 32'h9ABCDEF0, 32'hFEFEFEFE, 4'hF, 32'hFEFEFEFE, 4'hF, 1'b1);
        send(2'b10, 32'h33221178, 32'h77665544, 32'h332211FB, 4'h1, 32'h77665544, 4'h0, 1'b0);
        send(2'b10, 32'h030201FF, 32'h07060504, 32'h04030201, 4'h0, 32'hFD070605, 4'h8, 1'b0);
        // Terminate while idle
        send(2'b10, 32'h00000087, 32'h0, 32'hFEFEFEFE, 4'hF, 32'hFEFEFEFE, 4'hF, 1'b1);
        // Start while in frame, then idle block while in frame
        send(2'b10, 32'h55555578, 32'h55555555, 32'h555555FB, 4'h1, 32'h55555555, 4'h0, 1'b0);
        send(2'b10, 32'h55555578, 32'h55555555, 32'hFEFEFEFE, 4'hF, 32'hFEFEFEFE, 4'hF, 1'b1);
        send(2'b10, 32'h55555578, 32'h55555555, 32'h555555FB, 4'h1, 32'h55555555, 4'h0, 1'b0);
        send(2'b10, 32'h0000001E, 32'h0,        32'hFEFEFEFE, 4'hF, 32'hFEFEFEFE, 4'hF, 1'b1);
        // Ordered set while idle; idle block carrying an illegal code
        send(2'b10, 32'h0302014B, 32'h0, 32'h0302019C, 4'h1, 32'h07070707, 4'hF, 1'b0);
        send(2'b10, 32'h00009E1E, 32'h0, 32'h0707FEFE, 4'hF, 32'h07070707, 4'hF, 1'b1);
        gap(3);

        // Stray second-half beat while waiting for a header
        beat(1'b0, 2'b00, 32'hCAFEF00D);
        lone_q.push_back(cyc + 1);
        gap(3);
        // Two header beats in a row: second one starts the real block
        beat(1'b1, 2'b01, 32'hBADBAD00);
        beat(1'b1, 2'b10, 32'h0000001E);
        lone_q.push_back(cyc + 1);
        begin
            exp_t e;
            beat(1'b0, 2'b00, 32'h0);
            e.cyc = cyc + 1; e.rxd = 32'h07070707; e.rxc = 4'hF; e.err = 1'b0;
            exp_q.push_back(e);
            e.cyc = cyc + 2;
            exp_q.push_back(e);
        end
        gap(4);

        // Reset between halves of a block
        beat(1'b1, 2'b10, 32'h55555578);
        @(negedge clk);
        rx_valid = 1'b0;
        rst      = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("midreset");
        rst = 1'b0;
        gap(1);
        send(2'b10, 32'h55555578, 32'h55555555, 32'h555555FB, 4'h1, 32'h55555555, 4'h0, 1'b0);
        gap(2);

        // Drain with a bounded wait
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        gap(3);
        chk("words_outstanding", 64'(exp_q.size()), 64'h0);
        chk("errs_outstanding",  64'(lone_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/xgmii_decoder.md
# xgmii_decoder

64b/66b receive-side decoder: accepts descrambled 66-bit blocks as a 2-bit sync header plus two 32-bit halves, and regenerates 32-bit XGMII receive words with per-lane control flags. It sits between the descrambler and the RX MAC and inverts the transmit-path encoder. It also enforces the frame sequence (start/data/terminate) and reports decoding violations.

## Interface
- DATA_WIDTH, 32, XGMII/block-half width. Only 32 is supported.
- CTRL_WIDTH, 4, XGMII control bits per word. Only 4 is supported.
- HDR_WIDTH, 2, sync header width. Only 2 is supported.
- i_clk  in  1  single clock for all logic.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_data  in  32  block half. First half is payload bits [31:0]; second half is [63:32].
- i_rx_sync_hdr  in  2  sync header, sampled only with the first half.
- i_rx_hdr_valid  in  1  marks the current beat as the first half of a block.
- i_rx_valid  in  1  beat qualifier. Beats with i_rx_valid=0 are ignored.
- o_xgmii_rxd  out  32  decoded lanes 0-3, then lanes 4-7 on the next cycle.
- o_xgmii_rxc  out  4  per-lane control flags, bit n = lane n of the word.
- o_xgmii_valid  out  1  o_xgmii_rxd/rxc carry a decoded word.
- o_decode_err  out  1  one-cycle pulse on any block or sequence violation.

## Operation
- Assembler FSM has two states, HALF0 and HALF1.
  - HALF0: a valid beat with i_rx_hdr_valid=1 latches the low half and the header, then goes to HALF1. A valid beat with i_rx_hdr_valid=0 is dropped and pulses o_decode_err.
  - HALF1: a valid beat with i_rx_hdr_valid=0 completes the block, goes to HALF0, and registers the decode. A valid beat with i_rx_hdr_valid=1 discards the partial block, pulses o_decode_err, and is taken as a new first half (stays in HALF1).
- Sync header decode:
  - 01 = data block: 8 data lanes, rxc=0.
  - 10 = control block: type byte = payload[7:0].
  - 00 or 11 = invalid block: error block plus o_decode_err.
- Control block types (lane k = payload byte k; /I/=0x07, /S/=0xFB, /T/=0xFD, /E/=0xFE, /Q/=0x9C):
  - 0x1E: eight 7-bit codes at payload[63:8]. Code 0x00 -> /I/, 0x1E -> /E/, any other code -> /E/ with err.
  - 0x78: lane0 /S/, lanes1-7 data from bytes 1-7.
  - 0x33: lanes0-3 /I/, lane4 /S/, lanes5-7 data from bytes 5-7.
  - 0x4B: lane0 /Q/, lanes1-3 data from bytes 1-3, lanes4-7 /I/.
  - Terminate /T/ at lane k, with types 0x87,0x99,0xAA,0xB4,0xCC,0xD2,0xE1,0xFF for k=0..7:
    - lanes <k carry data bytes 1..k;
    - lane k is /T/;
    - lanes >k are /I/.
  - Any other type: error block plus err.
- Error block: all lanes 0xFE, rxc=0xFF.
- Frame FSM has two states, IDLE and IN_FRAME; reset state is IDLE.
  - 0x78 or 0x33 moves IDLE->IN_FRAME.
  - Terminate blocks move IN_FRAME->IDLE.
  - A data block in IDLE, a start in IN_FRAME, or a terminate in IDLE produces an error block plus err and forces IDLE.
  - An invalid block received in IN_FRAME forces IDLE.
  - 0x1E and 0x4B received in IN_FRAME produce an error block plus err and force IDLE.
- Rxc lane bit is 1 for every control character, including /E/ substitutions.

## Timing
- Reset values: o_xgmii_rxd=0x07070707, o_xgmii_rxc=0xF, o_xgmii_valid=0, o_decode_err=0. Assembler state is HALF0, frame state IDLE, output stage empty.
- Latency: second half accepted at cycle N -> lanes0-3 at N+1 and lanes4-7 at N+2, each with o_xgmii_valid=1.
- Back-to-back input at one beat per cycle gives continuous output, with o_xgmii_valid held at 1.
- The output stage never overflows, since a new block needs at least 2 beats. There is no backpressure.
- Input gaps (i_rx_valid=0) hold assembler state. Gaps produce o_xgmii_valid=0 cycles, during which rxd/rxc hold their last value.
- o_decode_err is asserted in the same cycle as the first output word of the offending block. For a misaligned beat, it is asserted the cycle after that beat.
- Reset mid-block discards the partial and the queued output word. The first word after reset comes from a fully reassembled block.

## Test plan
- Idle block: hdr 10, halves 0x0000001E / 0x00000000 -> two words 0x07070707, rxc 0xF, err 0.
- Frame: start 0x78 with data bytes 0x55, then data hdr 01 0xDDCCBBAA/0x44332211, then 0x87 terminate.
  - Start block -> 0x555555FB rxc 0x1, then 0x55555555 rxc 0x0.
  - Data block -> 0xDDCCBBAA rxc 0x0, then 0x44332211 rxc 0x0.
  - Terminate block -> 0x070707FD rxc 0xF, then 0x07070707 rxc 0xF.
  - No errors throughout.
- Terminate type 0xCC with bytes 1-4 = 0x11,0x22,0x33,0x44 -> 0x44332211 rxc 0x0, then 0x070707FD rxc 0xF.
- Sync header 11, or type 0x5A -> 0xFEFEFEFE rxc 0xF on both words, one err pulse.
- Data block while IDLE -> error block and err. A start block then arriving in IDLE is accepted normally.
- Two consecutive i_rx_hdr_valid=1 beats -> one err pulse, and the second beat starts a correctly decoded block. Reset asserted between halves -> outputs return to reset values, with no stale word emitted.
